// File: rtl/seq_arr_mul.sv
// seq_arr_mul: iterative shift-add WIDTH x WIDTH multiplier, one partial product per clock
// Ports: clk, rst_n (sync active-low); Start/Signed/A/B sampled while Busy=0;
//        Busy high while an operation runs; Done one-cycle pulse; Result 2*WIDTH-bit product held until next Done.
// Option: define SEQ_ARR_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_arr_mul #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state, w_next;
  logic [2*WIDTH:0] r_acc, w_acc_it, w_acc_nx;
  logic [WIDTH-1:0] r_mcand, r_mplier, w_a_mag, w_b_mag;
  logic [WIDTH:0] w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic r_neg, r_busy, r_done, w_last, w_skip;
  // Signed operands are multiplied as magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
  assign w_a_mag = (Signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag = (Signed && B[WIDTH-1]) ? -B : B;
  // The extra accumulator bit catches the carry of the upper-half add before the right shift.
  assign w_sum = r_acc[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_it = {w_sum, r_acc[WIDTH-1:0]} >> 1;
  assign w_last = r_cnt == CNT_W'(WIDTH - 1);
`ifdef SEQ_ARR_MUL_EARLY_TERM_EN
  // No set bits left: apply all outstanding shifts at once.
  assign w_skip = r_mplier == '0;
  assign w_acc_nx = w_skip ? r_acc >> (32'(WIDTH) - 32'(r_cnt)) : w_acc_it;
`else
  assign w_skip = 1'b0;
  assign w_acc_nx = w_acc_it;
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && Start) ? RUN :
             (r_state == RUN && (w_skip || w_last)) ? FIN :
             (r_state == FIN) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == FIN;
      if (r_state == IDLE && Start) begin
        r_mcand  <= w_a_mag;
        r_mplier <= w_b_mag;
        r_neg    <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
      if (r_state == RUN) begin
        r_acc    <= w_acc_nx;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (r_state == FIN) begin
        r_result <= r_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
        r_busy   <= 1'b0;
      end
    end
  end
  assign Busy = r_busy;
  assign Done = r_done;
  assign Result = r_result;
endmodule

// File: tb/tb_seq_arr_mul.sv
// tb_seq_arr_mul: directed and random checks of seq_arr_mul against an operation-level model
module tb_seq_arr_mul;
  localparam int W = 4;
`ifdef SEQ_ARR_MUL_EARLY_TERM_EN
  localparam int L_3X1 = 3;
  localparam int L_BZ = 2;
  localparam int L_7X3 = 4;
`else
  localparam int L_3X1 = 5;
  localparam int L_BZ = 5;
  localparam int L_7X3 = 5;
`endif
  logic clk = 0, rst_n = 0, Start = 0, Signed = 0;
  logic [W-1:0] A = '0, B = '0;
  logic Busy, Done;
  logic [2*W-1:0] Result;
  int checks = 0, errors = 0;
  int e = 0, m_end = 0;
  logic m_busy = 0, m_done = 0;
  logic [2*W-1:0] m_res = '0, m_prod = '0;

  seq_arr_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] prod(logic [W-1:0] a, logic [W-1:0] b, logic s);
    longint x = s ? longint'($signed(a)) : longint'(a);
    longint y = s ? longint'($signed(b)) : longint'(b);
    longint p = x * y;
    return p[2*W-1:0];
  endfunction

  function automatic int lat(logic [W-1:0] b, logic s);
`ifdef SEQ_ARR_MUL_EARLY_TERM_EN
    logic [W-1:0] mag = (s && b[W-1]) ? -b : b;
    int h = 0;
    if (mag == '0) return 2;
    for (int i = 0; i < W; i++) if (mag[i]) h = i;
    return (h + 1 == W) ? W + 1 : h + 3;
`else
    return W + 1 + 0 * int'({b, s});
`endif
  endfunction

  always @(posedge clk) begin
    e <= e + 1;
    if (!rst_n) begin
      m_busy <= 0;
      m_done <= 0;
      m_res  <= '0;
    end else begin
      m_done <= 0;
      if (m_busy && e == m_end) begin
        m_busy <= 0;
        m_done <= 1;
        m_res  <= m_prod;
      end else if (!m_busy && Start) begin
        m_busy <= 1;
        m_prod <= prod(A, B, Signed);
        m_end  <= e + lat(B, Signed);
      end
    end
  end

  always @(negedge clk) if (e > 0) begin
    chk("busy", int'(Busy), int'(m_busy));
    chk("done", int'(Done), int'(m_done));
    chk("result", int'(Result), int'(m_res));
    if (Busy && Done) chk("busy_done_overlap", 1, 0);
  end

  task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic s, logic [2*W-1:0] er, int el);
    int n = 0;
    @(negedge clk); A = a; B = b; Signed = s; Start = 1;
    @(negedge clk); Start = 0;
    while (!Done && n < 3 * W) begin @(negedge clk); n++; end
    chk("latency", n, el);
    chk("op_result", int'(Result), int'(er));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!Done && n < 4 * W);
  endtask

  task automatic count_done(int cyc, output int c);
    c = 0;
    repeat (cyc) begin @(negedge clk); if (Done) c++; end
  endtask

  initial begin
    int n, c;
    logic [W-1:0] pa, pb, ra, rb;
    logic rs;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_result", int'(Result), 0);
    rst_n = 1;
    run_op(4'd15, 4'd15, 0, 8'd225, 5);
    run_op(4'b1000, 4'b1000, 1, 8'h40, 5);
    run_op(4'b1101, 4'd5, 1, 8'hF1, 5);
    run_op(4'd3, 4'd1, 0, 8'd3, L_3X1);
    run_op(4'd9, 4'd0, 0, 8'd0, L_BZ);
    run_op(4'b1000, 4'b0111, 1, 8'hC8, 5);
    @(negedge clk); A = 7; B = 3; Signed = 0; Start = 1;
    @(negedge clk); Start = 0;
    @(negedge clk); A = 2; B = 2; Start = 1;
    @(negedge clk); Start = 0;
    n = 2;
    while (!Done && n < 3 * W) begin @(negedge clk); n++; end
    chk("ignore_latency", n, L_7X3);
    chk("ignore_result", int'(Result), 21);
    count_done(W + 3, c);
    chk("ignore_single_done", c, 0);
    pa = 4'd3; pb = 4'd8;
    @(negedge clk); A = pa; B = pb; Signed = 0; Start = 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      if (k > 0) chk("b2b_gap", n, W + 2);
      chk("b2b_result", int'(Result), int'(prod(pa, pb, 0)));
      pa = W'(k + 4); pb = W'(9 + k);
      A = pa; B = pb;
    end
    Start = 0;
    wait_done(n);
    count_done(2, c);
    @(negedge clk); A = 5; B = 6; Signed = 0; Start = 1;
    @(negedge clk); Start = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_done", int'(Done), 0);
    chk("abort_result", int'(Result), 0);
    rst_n = 1;
    count_done(W + 3, c);
    chk("abort_no_done", c, 0);
    run_op(4'd5, 4'd6, 0, 8'd30, 5);
    repeat (200) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rs, prod(ra, rb, rs), lat(rb, rs));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
